// File: rtl/id_ex_hazard_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_hazard_stage
//  Description : ID/EX pipeline register with data-hazard handling.
//                - RAW hazards are resolved by forwarding into the captured
//                  operands. Sources, highest priority first: EX result,
//                  MEM (ALU result or load data), WB write-back data.
//                - A load-use hazard raises stall, which holds PC and IF/ID,
//                  and inserts one bubble into EX.
//                - A branch flush inserts a bubble. Flush takes priority
//                  over stall.
//                - Saturating counters record stall and bubble events.
//  Ports       : clk/rst            clock, async active-high reset
//                *_ID               decode-stage fields and controls
//                ex_out             ALU result of the instruction in EX
//                RW_EX..mem_rdata   EX/MEM register fields, memory read data
//                RW_WB..wb_data     write-back port
//                flush              kill the instruction entering EX
//                stall              hold PC and IF/ID (combinational)
//                *_q                registered ID/EX outputs
//                stall_cnt/bubble_cnt  saturating event counters
//  Revision    : 1.0  initial release
// ============================================================================
module id_ex_hazard_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        rs_ID,
    input  logic [4:0]        rt_ID,
    input  logic              use_rs,
    input  logic              use_rt,
    input  logic [4:0]        RW_ID,
    input  logic [DATA_W-1:0] busA_ID,
    input  logic [DATA_W-1:0] busB_ID,
    input  logic [DATA_W-1:0] imm_ID,
    input  logic [DATA_W-1:0] PCnew_ID,
    input  logic              nPC_sel_ID,
    input  logic              MemWrite_ID,
    input  logic              MemtoReg_ID,
    input  logic              RegWrite_ID,
    input  logic              ALUSrc_ID,
    input  logic [3:0]        ALUctr_ID,
    input  logic [DATA_W-1:0] ex_out,
    input  logic [4:0]        RW_EX,
    input  logic              RegWrite_EX,
    input  logic              MemtoReg_EX,
    input  logic [DATA_W-1:0] out_EX,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [4:0]        RW_WB,
    input  logic              RegWrite_WB,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              stall,
    output logic [DATA_W-1:0] busA_q,
    output logic [DATA_W-1:0] busB_q,
    output logic [DATA_W-1:0] imm_q,
    output logic [DATA_W-1:0] PCnew_q,
    output logic [4:0]        RW_q,
    output logic              nPC_sel_q,
    output logic              MemWrite_q,
    output logic              MemtoReg_q,
    output logic              RegWrite_q,
    output logic              ALUSrc_q,
    output logic [3:0]        ALUctr_q,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic              w_hz;
    logic              w_bubble;
    logic              w_ex_valid;
    logic              w_mem_valid;
    logic              w_wb_valid;
    logic [DATA_W-1:0] w_mem_data;
    logic [DATA_W-1:0] busA_d;
    logic [DATA_W-1:0] busB_d;

    // A load currently in EX whose destination is read by the decode
    // instruction cannot be forwarded in time.
    assign w_hz = MemtoReg_q & RegWrite_q & (RW_q != 5'd0) &
                  ((use_rs & (rs_ID == RW_q)) | (use_rt & (rt_ID == RW_q)));

    // A flush discards the dependent instruction, so a stall would be useless.
    assign stall    = w_hz & ~flush;
    assign w_bubble = flush | w_hz;

    // A load in EX has no result yet, so EX forwards only ALU results.
    assign w_ex_valid  = RegWrite_q & ~MemtoReg_q & (RW_q != 5'd0);
    assign w_mem_valid = RegWrite_EX & (RW_EX != 5'd0);
    assign w_wb_valid  = RegWrite_WB & (RW_WB != 5'd0);
    assign w_mem_data  = MemtoReg_EX ? mem_rdata : out_EX;

    always_comb begin
        busA_d = busA_ID;
        if (w_ex_valid && (RW_q == rs_ID)) begin
            busA_d = ex_out;
        end else if (w_mem_valid && (RW_EX == rs_ID)) begin
            busA_d = w_mem_data;
        end else if (w_wb_valid && (RW_WB == rs_ID)) begin
            busA_d = wb_data;
        end
    end

    // busB carries the store data, so it is forwarded regardless of ALUSrc.
    always_comb begin
        busB_d = busB_ID;
        if (w_ex_valid && (RW_q == rt_ID)) begin
            busB_d = ex_out;
        end else if (w_mem_valid && (RW_EX == rt_ID)) begin
            busB_d = w_mem_data;
        end else if (w_wb_valid && (RW_WB == rt_ID)) begin
            busB_d = wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busA_q     <= '0;
            busB_q     <= '0;
            imm_q      <= '0;
            PCnew_q    <= '0;
            RW_q       <= '0;
            nPC_sel_q  <= 1'b0;
            MemWrite_q <= 1'b0;
            MemtoReg_q <= 1'b0;
            RegWrite_q <= 1'b0;
            ALUSrc_q   <= 1'b0;
            ALUctr_q   <= '0;
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            // Data fields are don't-care in a bubble; capture them anyway.
            busA_q  <= busA_d;
            busB_q  <= busB_d;
            imm_q   <= imm_ID;
            PCnew_q <= PCnew_ID;
            if (w_bubble) begin
                RW_q       <= '0;
                nPC_sel_q  <= 1'b0;
                MemWrite_q <= 1'b0;
                MemtoReg_q <= 1'b0;
                RegWrite_q <= 1'b0;
                ALUSrc_q   <= 1'b0;
                ALUctr_q   <= '0;
            end else begin
                RW_q       <= RW_ID;
                nPC_sel_q  <= nPC_sel_ID;
                MemWrite_q <= MemWrite_ID;
                MemtoReg_q <= MemtoReg_ID;
                RegWrite_q <= RegWrite_ID;
                ALUSrc_q   <= ALUSrc_ID;
                ALUctr_q   <= ALUctr_ID;
            end
            if (stall && (stall_cnt != C_CNT_MAX)) begin
                stall_cnt <= stall_cnt + C_CNT_ONE;
            end
            if (w_bubble && (bubble_cnt != C_CNT_MAX)) begin
                bubble_cnt <= bubble_cnt + C_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_hazard_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_hazard_stage
//  Description : Directed self-checking bench for id_ex_hazard_stage
//                (CNT_W = 4 so counter saturation is reachable).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_id_ex_hazard_stage;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    rs_ID, rt_ID, RW_ID, RW_EX, RW_WB;
    logic          use_rs, use_rt;
    logic [DW-1:0] busA_ID, busB_ID, imm_ID, PCnew_ID;
    logic          nPC_sel_ID, MemWrite_ID, MemtoReg_ID, RegWrite_ID, ALUSrc_ID;
    logic [3:0]    ALUctr_ID;
    logic [DW-1:0] ex_out, out_EX, mem_rdata, wb_data;
    logic          RegWrite_EX, MemtoReg_EX, RegWrite_WB, flush;
    logic          stall;
    logic [DW-1:0] busA_q, busB_q, imm_q, PCnew_q;
    logic [4:0]    RW_q;
    logic          nPC_sel_q, MemWrite_q, MemtoReg_q, RegWrite_q, ALUSrc_q;
    logic [3:0]    ALUctr_q;
    logic [CW-1:0] stall_cnt, bubble_cnt;

    int n_vec = 0;
    int n_err = 0;

    id_ex_hazard_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .use_rs(use_rs), .use_rt(use_rt),
        .RW_ID(RW_ID), .busA_ID(busA_ID), .busB_ID(busB_ID),
        .imm_ID(imm_ID), .PCnew_ID(PCnew_ID),
        .nPC_sel_ID(nPC_sel_ID), .MemWrite_ID(MemWrite_ID),
        .MemtoReg_ID(MemtoReg_ID), .RegWrite_ID(RegWrite_ID),
        .ALUSrc_ID(ALUSrc_ID), .ALUctr_ID(ALUctr_ID),
        .ex_out(ex_out), .RW_EX(RW_EX), .RegWrite_EX(RegWrite_EX),
        .MemtoReg_EX(MemtoReg_EX), .out_EX(out_EX), .mem_rdata(mem_rdata),
        .RW_WB(RW_WB), .RegWrite_WB(RegWrite_WB), .wb_data(wb_data),
        .flush(flush), .stall(stall),
        .busA_q(busA_q), .busB_q(busB_q), .imm_q(imm_q), .PCnew_q(PCnew_q),
        .RW_q(RW_q), .nPC_sel_q(nPC_sel_q), .MemWrite_q(MemWrite_q),
        .MemtoReg_q(MemtoReg_q), .RegWrite_q(RegWrite_q),
        .ALUSrc_q(ALUSrc_q), .ALUctr_q(ALUctr_q),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs_ID = 0; rt_ID = 0; use_rs = 0; use_rt = 0; RW_ID = 0;
        busA_ID = 0; busB_ID = 0; imm_ID = 0; PCnew_ID = 0;
        nPC_sel_ID = 0; MemWrite_ID = 0; MemtoReg_ID = 0; RegWrite_ID = 0;
        ALUSrc_ID = 0; ALUctr_ID = 0;
        ex_out = 0; out_EX = 0; mem_rdata = 0; wb_data = 0;
        RW_EX = 0; RegWrite_EX = 0; MemtoReg_EX = 0;
        RW_WB = 0; RegWrite_WB = 0; flush = 0;
    endtask

    // Decode a load into register r (no sources used).
    task automatic decode_lw(input logic [4:0] r);
        idle_inputs();
        RW_ID = r; RegWrite_ID = 1; MemtoReg_ID = 1; ALUSrc_ID = 1;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        tick(); tick();
        rst = 0;
        tick();
        chk("reset_stall", {31'd0, stall}, 0);
        chk("reset_RegWrite_q", {31'd0, RegWrite_q}, 0);

        // ---- back-to-back ALU forwarding from EX ----
        idle_inputs();
        RW_ID = 3; RegWrite_ID = 1; ALUctr_ID = 4'h2; busA_ID = 32'h11;
        imm_ID = 32'h1234; PCnew_ID = 32'h40;
        tick();
        chk("add_RW_q", RW_q, 3);
        chk("add_ALUctr_q", ALUctr_q, 2);
        chk("add_imm_q", imm_q, 32'h1234);
        chk("add_PCnew_q", PCnew_q, 32'h40);
        idle_inputs();
        rs_ID = 3; use_rs = 1; busA_ID = 32'h99; ex_out = 32'h55;
        #1 chk("alu_stall", {31'd0, stall}, 0);
        tick();
        chk("ex_fwd_busA", busA_q, 32'h55);

        // ---- load-use: one stall, one bubble, then forward load data ----
        decode_lw(4);
        tick();
        chk("lw_MemtoReg_q", {31'd0, MemtoReg_q}, 1);
        idle_inputs();
        rt_ID = 4; use_rt = 1; RW_ID = 6; RegWrite_ID = 1; busB_ID = 32'h77;
        #1 chk("lu_stall", {31'd0, stall}, 1);
        tick();
        chk("lu_bubble_RegWrite_q", {31'd0, RegWrite_q}, 0);
        chk("lu_bubble_RW_q", RW_q, 0);
        chk("lu_bubble_cnt", bubble_cnt, 1);
        chk("lu_stall_cnt", stall_cnt, 1);
        chk("lu_stall_cleared", {31'd0, stall}, 0);
        RW_EX = 4; RegWrite_EX = 1; MemtoReg_EX = 1; mem_rdata = 32'hAB;
        out_EX = 32'hDEAD;
        tick();
        chk("mem_load_fwd_busB", busB_q, 32'hAB);
        chk("lu_retry_RW_q", RW_q, 6);

        // ---- priority EX > MEM > WB, then register 0 ----
        idle_inputs();
        RW_ID = 5; RegWrite_ID = 1;
        tick();
        idle_inputs();
        rs_ID = 5; use_rs = 1; busA_ID = 32'h33;
        ex_out = 1;
        RW_EX = 5; RegWrite_EX = 1; out_EX = 2;
        RW_WB = 5; RegWrite_WB = 1; wb_data = 3;
        tick();
        chk("prio_ex", busA_q, 1);
        tick();
        chk("prio_mem", busA_q, 2);
        RegWrite_EX = 0;
        tick();
        chk("prio_wb", busA_q, 3);
        idle_inputs();
        RW_ID = 0; RegWrite_ID = 1;
        tick();
        rs_ID = 0; rt_ID = 0; use_rs = 1; use_rt = 1;
        busA_ID = 32'h44; busB_ID = 32'h66; ex_out = 32'hE1;
        RW_EX = 0; RegWrite_EX = 1; out_EX = 32'hE2;
        RW_WB = 0; RegWrite_WB = 1; wb_data = 32'hE3;
        tick();
        chk("r0_busA", busA_q, 32'h44);
        chk("r0_busB", busB_q, 32'h66);

        // ---- hazard together with flush ----
        decode_lw(7);
        tick();
        idle_inputs();
        rs_ID = 7; use_rs = 1; RW_ID = 8; RegWrite_ID = 1; flush = 1;
        #1 chk("hz_flush_stall", {31'd0, stall}, 0);
        tick();
        chk("hz_flush_RegWrite_q", {31'd0, RegWrite_q}, 0);
        chk("hz_flush_bubble_cnt", bubble_cnt, 2);
        chk("hz_flush_stall_cnt", stall_cnt, 1);
        idle_inputs();
        RW_ID = 9; RegWrite_ID = 1; MemWrite_ID = 1; nPC_sel_ID = 1; flush = 1;
        tick();
        chk("flush_RW_q", RW_q, 0);
        chk("flush_MemWrite_q", {31'd0, MemWrite_q}, 0);
        chk("flush_bubble_cnt", bubble_cnt, 3);
        flush = 0;

        // ---- 20 load-use events: both counters saturate at 15 ----
        for (int i = 0; i < 20; i++) begin
            decode_lw(10);
            tick();
            idle_inputs();
            rt_ID = 10; use_rt = 1;
            tick();
        end
        chk("sat_stall_cnt", stall_cnt, 15);
        chk("sat_bubble_cnt", bubble_cnt, 15);

        // ---- asynchronous reset in the middle of a stall ----
        decode_lw(11);
        tick();
        idle_inputs();
        rs_ID = 11; use_rs = 1;
        #1 chk("pre_rst_stall", {31'd0, stall}, 1);
        rst = 1;
        #1;
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_RW_q", RW_q, 0);
        chk("rst_MemtoReg_q", {31'd0, MemtoReg_q}, 0);
        chk("rst_busA_q", busA_q, 0);
        chk("rst_imm_q", imm_q, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_bubble_cnt", bubble_cnt, 0);
        tick();
        chk("rst_held_stall", {31'd0, stall}, 0);
        rst = 0;
        tick();
        chk("post_rst_stall_cnt", stall_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
